// File: rtl/hit_pulse_gen_pkg.sv
// Shared types and constants for the hit pulse generator.
package hit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    HIT,
    LOCKOUT,
    WAIT_REL
  } hit_state_t;

  localparam int IGN_CNT_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hit_pulse_gen_if.sv
// Press input and hit/armed/ignore-count outputs of the hit pulse generator.
interface hit_pulse_gen_if;
  import hit_pkg::*;

  logic                 in_raw;
  logic                 hit;
  logic                 armed;
  logic [IGN_CNT_W-1:0] ign_cnt;

  modport master (output in_raw, input hit, input armed, input ign_cnt);
  modport slave  (input in_raw, output hit, output armed, output ign_cnt);

endinterface

// File: rtl/hit_pulse_gen_sync_ff.sv
// N-flop synchroniser for an asynchronous single-bit input, reset to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/hit_pulse_gen.sv
// Synchronise, debounce and lock out a raw press line into single-cycle hit pulses.
// Optional rejected-press counter enabled with macro HIT_IGNORE_CNT_EN.
//
//   state    | meaning
//   IDLE     | armed, waiting for sync high
//   DEBOUNCE | counting consecutive high samples
//   HIT      | one-cycle hit pulse
//   LOCKOUT  | post-hit dead time, input ignored
//   WAIT_REL | dead time over, waiting for release
module hit_pulse_gen
  import hit_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 50_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  hit_pulse_gen_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  logic             sync;
  hit_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             armed_q, armed_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.in_raw),
    .q_o   (sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = DEBOUNCE;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        // A low sample aborts even on the final count cycle.
        if (!sync)                  state_d = IDLE;
        else if (cnt_q == DEB_LAST) state_d = HIT;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      HIT: begin
        state_d = LOCKOUT;
        cnt_d   = '0;
      end
      LOCKOUT: begin
        if (cnt_q == LOCK_LAST) state_d = WAIT_REL;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      WAIT_REL: begin
        if (!sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    hit_d   = (state_d == HIT);
    armed_d = (state_d == IDLE) || (state_d == DEBOUNCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      armed_q <= armed_d;
    end
  end

  assign bus.hit   = hit_q;
  assign bus.armed = armed_q;

`ifdef HIT_IGNORE_CNT_EN
  logic                 sync_prev_q;
  logic [IGN_CNT_W-1:0] ign_q, ign_d;

  always_comb begin
    ign_d = ign_q;
    if ((state_q == LOCKOUT || state_q == WAIT_REL) && sync && !sync_prev_q
        && (ign_q != '1))
      ign_d = ign_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_prev_q <= 1'b0;
      ign_q       <= '0;
    end else begin
      sync_prev_q <= sync;
      ign_q       <= ign_d;
    end
  end

  assign bus.ign_cnt = ign_q;
`else
  assign bus.ign_cnt = '0;
`endif

endmodule

// File: tb/tb_hit_pulse_gen.sv
// Self-checking bench for hit_pulse_gen against a run-length/lockout reference model.
module tb_hit_pulse_gen;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int LK = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  hit_pulse_gen_if ifc ();

  hit_pulse_gen #(
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DB),
    .LOCKOUT_CYCLES  (LK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: in_raw delayed SS edges gives the sampled level. While armed,
  // a run of DB+1 high samples fires a hit; then one hit cycle plus LK dead cycles,
  // then a wait for a low sample before re-arming. Rising samples while disarmed
  // (except the hit cycle) count as ignored presses.
  bit m_sh[SS];
  int m_phase;   // 0 armed, 1 hit cycle, 2 dead time, 3 waiting release
  int m_run;
  int m_left;
  bit m_prev;
  int m_ign;
  bit m_hit;
  bit m_armed;

  function automatic void model_reset();
    for (int i = 0; i < SS; i++) m_sh[i] = 1'b0;
    m_phase = 0;
    m_run   = 0;
    m_left  = 0;
    m_prev  = 1'b0;
    m_ign   = 0;
    m_hit   = 1'b0;
    m_armed = 1'b1;
  endfunction

  function automatic void model_step(input bit v);
    bit s;
    s = m_sh[SS-1];
    for (int i = SS - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = v;
    m_hit = 1'b0;
    if ((m_phase == 2 || m_phase == 3) && s && !m_prev && m_ign < 255) m_ign++;
    m_prev = s;
    case (m_phase)
      0: begin
        m_run = s ? m_run + 1 : 0;
        if (m_run == DB + 1) begin
          m_hit   = 1'b1;
          m_phase = 1;
          m_run   = 0;
        end
      end
      1: begin
        m_phase = 2;
        m_left  = LK;
      end
      2: begin
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
      default: begin
        if (!s) m_phase = 0;
      end
    endcase
    m_armed = (m_phase == 0);
  endfunction

  function automatic int exp_ign();
`ifdef HIT_IGNORE_CNT_EN
    return m_ign;
`else
    return 0;
`endif
  endfunction

  task automatic step(input bit v);
    @(negedge clk);
    ifc.in_raw = v;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic press_until_hit(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      if (ifc.hit === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.in_raw = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.hit !== 1'b0 || ifc.armed !== 1'b1 || ifc.ign_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_hold: hit=%0b armed=%0b ign=%0d, want 0 1 0", ifc.hit, ifc.armed, ifc.ign_cnt);
    end
    ifc.in_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ifc.hit !== 1'b0 || ifc.armed !== 1'b1 || ifc.ign_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: hit=%0b armed=%0b ign=%0d, want 0 1 0", ifc.hit, ifc.armed, ifc.ign_cnt);
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int nh = 0;
    for (int i = 0; i < 42; i++) begin
      step(i < 30);
      checks++;
      if (ifc.hit !== m_hit || ifc.armed !== m_armed) begin
        errors++;
        $display("FAIL clean_press cyc %0d: hit=%0b armed=%0b, want %0b %0b", i, ifc.hit, ifc.armed, m_hit, m_armed);
      end
      if (ifc.hit === 1'b1) begin
        nh++;
        if (first < 0) first = i;
      end
    end
    // hit rises on the 7th edge counting the one that first samples in_raw high
    checks++;
    if (nh !== 1 || first !== 6) begin
      errors++;
      $display("FAIL clean_press_latency: hits=%0d at edge %0d, want 1 at 6", nh, first);
    end
  endtask

  task automatic test_glitch();
    int nh = 0;
    for (int i = 0; i < 14; i++) begin
      step(i < 3);
      checks++;
      if (ifc.hit !== 1'b0 || ifc.armed !== 1'b1) begin
        errors++;
        $display("FAIL glitch cyc %0d: hit=%0b armed=%0b, want 0 1", i, ifc.hit, ifc.armed);
      end
      if (ifc.hit === 1'b1) nh++;
    end
    checks++;
    if (nh !== 0) begin
      errors++;
      $display("FAIL glitch_count: hits=%0d want 0", nh);
    end
  endtask

  task automatic test_bounce();
    int first = -1;
    int nh = 0;
    for (int i = 0; i < 36; i++) begin
      step(i != 1 && i < 24);
      checks++;
      if (ifc.hit !== m_hit || ifc.armed !== m_armed) begin
        errors++;
        $display("FAIL bounce cyc %0d: hit=%0b armed=%0b, want %0b %0b", i, ifc.hit, ifc.armed, m_hit, m_armed);
      end
      if (ifc.hit === 1'b1) begin
        nh++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (nh !== 1 || first !== 2 + 6) begin
      errors++;
      $display("FAIL bounce_latency: hits=%0d at edge %0d, want 1 at 8", nh, first);
    end
  endtask

  task automatic test_relock();
    bit seen;
    int m0;
    int nh = 0;
    m0 = m_ign;
    press_until_hit(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL relock_first_hit: no hit within 20 cycles, want one");
    end
    step(1'b1);
    step(1'b0);
    repeat ($urandom_range(1, 3)) begin
      step(1'b1);
      if (ifc.hit === 1'b1) nh++;
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0);
      checks++;
      if (ifc.hit !== m_hit || ifc.armed !== m_armed || ifc.ign_cnt !== 8'(exp_ign())) begin
        errors++;
        $display("FAIL relock cyc %0d: hit=%0b armed=%0b ign=%0d, want %0b %0b %0d", i, ifc.hit, ifc.armed, ifc.ign_cnt, m_hit, m_armed, exp_ign());
      end
      if (ifc.hit === 1'b1) nh++;
    end
    checks++;
    if (nh !== 0) begin
      errors++;
      $display("FAIL relock_second_hit: hits=%0d want 0", nh);
    end
`ifdef HIT_IGNORE_CNT_EN
    checks++;
    if (int'(ifc.ign_cnt) !== m0 + 1) begin
      errors++;
      $display("FAIL relock_ign: ign=%0d want %0d", ifc.ign_cnt, m0 + 1);
    end
`endif
  endtask

  task automatic test_reset_lockout();
    bit seen;
    int first = -1;
    repeat (4) step(1'b0);
    press_until_hit(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_lock_first_hit: no hit within 20 cycles, want one");
    end
    repeat (3) step(1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ifc.hit !== 1'b0 || ifc.armed !== 1'b1 || ifc.ign_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_lock_async: hit=%0b armed=%0b ign=%0d, want 0 1 0", ifc.hit, ifc.armed, ifc.ign_cnt);
    end
    @(negedge clk);
    ifc.in_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(i < 12);
      checks++;
      if (ifc.hit !== m_hit || ifc.armed !== m_armed) begin
        errors++;
        $display("FAIL rst_lock_repress cyc %0d: hit=%0b armed=%0b, want %0b %0b", i, ifc.hit, ifc.armed, m_hit, m_armed);
      end
      if (ifc.hit === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first !== 6) begin
      errors++;
      $display("FAIL rst_lock_latency: hit at edge %0d, want 6", first);
    end
  endtask

  task automatic test_random();
    bit v = 1'b0;
    int len;
    int cyc = 0;
    while (cyc < 400) begin
      v = ~v;
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        step(v);
        cyc++;
        checks++;
        if (ifc.hit !== m_hit || ifc.armed !== m_armed || ifc.ign_cnt !== 8'(exp_ign())) begin
          errors++;
          $display("FAIL random cyc %0d: hit=%0b armed=%0b ign=%0d, want %0b %0b %0d", cyc, ifc.hit, ifc.armed, ifc.ign_cnt, m_hit, m_armed, exp_ign());
        end
      end
    end
  endtask

  task automatic test_ign_saturate();
    bit seen;
    for (int n = 0; n < 110; n++) begin
      repeat (4) step(1'b0);
      press_until_hit(seen);
      checks++;
      if (!seen || m_hit !== 1'b1) begin
        errors++;
        $display("FAIL sat_hit iter %0d: seen=%0b model_hit=%0b, want 1 1", n, seen, m_hit);
      end
      for (int k = 0; k < 8; k++) step(k % 2 == 1);
    end
    repeat (6) step(1'b0);
    checks++;
    if (ifc.ign_cnt !== 8'(exp_ign())) begin
      errors++;
      $display("FAIL sat_model: ign=%0d want %0d", ifc.ign_cnt, exp_ign());
    end
`ifdef HIT_IGNORE_CNT_EN
    checks++;
    if (ifc.ign_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_ceiling: ign=%0d want 255", ifc.ign_cnt);
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    ifc.in_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_relock();
    test_reset_lockout();
    test_random();
    test_ign_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
